// File: rtl/char_pkg.sv
// char_pkg: shared state encoding, Gray helper and synchronizer depth for the cell sweeper.
`default_nettype none

package char_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic logic [31:0] gray(input logic [31:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_sync2.sv
// char_sync2: two-flop synchronizer bringing the asynchronous cell output into the clk domain.
`default_nettype none

module char_sync2
  import char_pkg::*;
(
  input  logic clk,
  input  logic rn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cell_char_sweeper.sv
// cell_char_sweeper: steps a library cell through all input vectors and checks it against a truth table.
// Define CHAR_GRAY_ORDER_EN to sweep in Gray order (one input toggle per step) instead of binary.
`default_nettype none

module cell_char_sweeper
  import char_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 4,
  parameter int CW         = 8
) (
  input  logic                 clk,
  input  logic                 rn,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   truth,
  input  logic                 y,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      fail_vec,
  output logic                 fail_valid
);

  state_t          state, state_nxt;
  logic            y_s;
  logic [N_IN-1:0] idx, idx_inc, code_inc;
  logic [CW-1:0]   cnt;
  logic            settled, last, mismatch;

  char_sync2 u_sync (
    .clk (clk),
    .rn  (rn),
    .d   (y),
    .q   (y_s)
  );

  assign idx_inc  = idx + 1'b1;
`ifdef CHAR_GRAY_ORDER_EN
  assign code_inc = N_IN'(gray(32'(idx_inc)));
`else
  assign code_inc = idx_inc;
`endif

  assign settled  = (cnt == CW'(SETTLE_CYC - 1));
  assign last     = (idx == {N_IN{1'b1}});
  // The compare index is the applied vector itself, so Gray order needs no remapping of truth.
  assign mismatch = (y_s != truth[vec]);

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (settled) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == SAMPLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      idx        <= '0;
      vec        <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            vec        <= '0;
            cnt        <= '0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
          end
        end
        SETTLE: cnt <= cnt + 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (!last) begin
            idx <= idx_inc;
            vec <= code_inc;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cell_char_sweeper.sv
// tb_cell_char_sweeper: directed self-checking bench driving gate models through full sweeps.
`default_nettype none

module tb_cell_char_sweeper;

  localparam int N_IN       = 2;
  localparam int SETTLE_CYC = 4;
  localparam int CW         = 8;
  localparam int STEP       = SETTLE_CYC + 1;
  localparam int NVEC       = 2**N_IN;
  localparam int SWEEP      = NVEC * STEP + 1;

  logic              clk, rn, start, y;
  logic [NVEC-1:0]   truth;
  logic [N_IN-1:0]   vec, fail_vec;
  logic              busy, done, fail_valid;
  logic [N_IN:0]     err_cnt;
  int                model;
  int                tests, fails;

  cell_char_sweeper #(.N_IN(N_IN), .SETTLE_CYC(SETTLE_CYC), .CW(CW)) dut (
    .clk        (clk),
    .rn         (rn),
    .start      (start),
    .truth      (truth),
    .y          (y),
    .vec        (vec),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: 0 AND2, 1 NAND2, 2 tied low, 3 NOR2
  always_comb begin
    case (model)
      0:       y = vec[0] & vec[1];
      1:       y = ~(vec[0] & vec[1]);
      3:       y = ~(vec[0] | vec[1]);
      default: y = 1'b0;
    endcase
  end

  function automatic int code(input int i);
`ifdef CHAR_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is driven just after an edge; edge k=1 samples it, DONE is entered at edge SWEEP.
  task automatic do_sweep(input string tag, input bit hold);
    int i;
    start = 1'b1;
    for (int k = 1; k <= SWEEP; k++) begin
      tick();
      if (!hold) start = 1'b0;
      i = (k - 1) / STEP;
      if (i > NVEC - 1) i = NVEC - 1;
      check({tag, "_vec"},  32'(vec),  32'(code(i)));
      check({tag, "_busy"}, 32'(busy), 32'(k < SWEEP));
      check({tag, "_done"}, 32'(done), 32'(k == SWEEP));
      if (k == 1) begin
        check({tag, "_errclr"}, 32'(err_cnt),    32'd0);
        check({tag, "_fvclr"},  32'(fail_valid), 32'd0);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_wait"}, 32'(done), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rn    = 1'b0;
    start = 1'b0;
    truth = 4'b1000;
    model = 0;
    repeat (3) tick();
    check("rst_vec",  32'(vec),        32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_done", 32'(done),       32'd0);
    check("rst_err",  32'(err_cnt),    32'd0);
    check("rst_fvec", 32'(fail_vec),   32'd0);
    check("rst_fval", 32'(fail_valid), 32'd0);
    rn = 1'b1;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // AND2 against its own truth table: clean sweep
    do_sweep("and", 1'b0);
    check("and_err",  32'(err_cnt),    32'd0);
    check("and_fval", 32'(fail_valid), 32'd0);

    // NAND2 against the AND2 table: every vector disagrees
    model = 1;
    do_sweep("nand", 1'b0);
    check("nand_err",  32'(err_cnt),    32'd4);
    check("nand_fvec", 32'(fail_vec),   32'd0);
    check("nand_fval", 32'(fail_valid), 32'd1);

    // Output stuck low against OR2 table, then rerun from DONE
    model = 2;
    truth = 4'b1110;
    do_sweep("or0", 1'b0);
    check("or0_err",  32'(err_cnt),    32'd3);
    check("or0_fvec", 32'(fail_vec),   32'd1);
    check("or0_fval", 32'(fail_valid), 32'd1);
    do_sweep("or0_re", 1'b0);
    check("or0_re_err",  32'(err_cnt),  32'd3);
    check("or0_re_fvec", 32'(fail_vec), 32'd1);

    // NOR2 against its own truth table
    model = 3;
    truth = 4'b0001;
    do_sweep("nor", 1'b0);
    check("nor_err",  32'(err_cnt),    32'd0);
    check("nor_fval", 32'(fail_valid), 32'd0);

    // Asynchronous reset during the settle window of vector 2
    model = 1;
    truth = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * STEP + 1) tick();
    check("mid_vec",  32'(vec),        32'(code(2)));
    check("mid_busy", 32'(busy),       32'd1);
    check("mid_err",  32'(err_cnt),    32'd2);
    check("mid_fval", 32'(fail_valid), 32'd1);
    rn = 1'b0;
    #1;
    check("arst_vec",  32'(vec),        32'd0);
    check("arst_busy", 32'(busy),       32'd0);
    check("arst_done", 32'(done),       32'd0);
    check("arst_err",  32'(err_cnt),    32'd0);
    check("arst_fvec", 32'(fail_vec),   32'd0);
    check("arst_fval", 32'(fail_valid), 32'd0);
    repeat (2) tick();
    rn = 1'b1;
    repeat (10) tick();
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_vec",  32'(vec),  32'd0);

    // start held high: no restart while busy, restart on the edge after DONE
    model = 0;
    do_sweep("hold", 1'b1);
    check("hold_err", 32'(err_cnt), 32'd0);
    tick();
    start = 1'b0;
    check("hold_re_busy", 32'(busy),    32'd1);
    check("hold_re_done", 32'(done),    32'd0);
    check("hold_re_vec",  32'(vec),     32'd0);
    check("hold_re_err",  32'(err_cnt), 32'd0);
    wait_done("hold_re");
    check("hold_re_fin", 32'(err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
